// File: rtl/add2_pkg.sv
// Shared definitions for the serial 2-bit-slice adder: slice width and controller states.
package add2_pkg;

  localparam int unsigned SLICE_W = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/add2c_slice.sv
// Combinational 2-bit adder slice with carry in/out; the only arithmetic element.
module add2c_slice
  import add2_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_sum_c,
  output logic               o_cout_c
);

  localparam int unsigned SUM_W = SLICE_W + 1;

  assign {o_cout_c, o_sum_c} = SUM_W'(i_a) + SUM_W'(i_b) + SUM_W'(i_cin);

endmodule

// File: rtl/serial_add2_ctrl.sv
// Sequencer adding two WIDTH-bit operands through one shared 2-bit slice, LSB slice first.
module serial_add2_ctrl
  import add2_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_busy;
  logic               r_done;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_load;
  logic               w_step;
  logic               w_last;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_part;
  logic [WIDTH:0]     r_sum;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;

  logic [31:0]        w_off;
  logic [SLICE_W-1:0] w_a_sl;
  logic [SLICE_W-1:0] w_b_sl;
  logic [SLICE_W-1:0] w_s;
  logic               w_cout;
  logic [WIDTH-1:0]   w_part_nxt;

  // State and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic; DONE accepts a new start so requests can run back-to-back
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == S_RUN);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // Select the current slice of each operand and merge the slice result into the partial sum
  assign w_off      = SLICE_W * 32'(r_idx);
  assign w_a_sl     = SLICE_W'(r_a >> w_off);
  assign w_b_sl     = SLICE_W'(r_b >> w_off);
  assign w_part_nxt = (r_part & ~(WIDTH'({SLICE_W{1'b1}}) << w_off)) | (WIDTH'(w_s) << w_off);

  add2c_slice u_slice (
    .i_a      (w_a_sl),
    .i_b      (w_b_sl),
    .i_cin    (r_carry),
    .o_sum_c  (w_s),
    .o_cout_c (w_cout)
  );

  // Operand capture, slice stepping and result update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
    end else if (w_load) begin
      r_a     <= a;
      r_b     <= b;
      r_part  <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
    end else if (w_step) begin
      r_part  <= w_part_nxt;
      r_carry <= w_cout;
      if (w_last) begin
        r_idx <= '0;
        r_sum <= {w_cout, w_part_nxt};
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;

endmodule
